// File: rtl/ysyx_25020037_axi_pkg.sv
// Shared AXI4-Lite response codes, access sizes, FSM encoding and request
// helpers for the LSU-side AXI-Lite master.
package ysyx_25020037_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_ADDR = ST_RD_ADDR,
    S_RD_DATA = ST_RD_DATA,
    S_WR_REQ  = ST_WR_REQ,
    S_WR_RESP = ST_WR_RESP,
    S_RESP    = ST_RESP
  } state_e;

  // Load-side attributes that must survive until the R beat arrives
  typedef struct packed {
    logic       sgn;
    logic [1:0] size;
  } ctl_t;

  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) || (size == SIZE_H && lo[0]) || (size == SIZE_W && lo != 2'b00);
  endfunction

  // EXOKAY counts as success; only SLVERR/DECERR flag an error
  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/ysyx_25020037_lsu_lane.sv
// Combinational byte-lane steering: store data replication/strobes and
// load lane extraction with sign/zero extension.
module ysyx_25020037_lsu_lane
  import ysyx_25020037_axi_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic        ld_sgn_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b1111;
    case (st_size_i)
      SIZE_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_addr_lo_i;
      end
      SIZE_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << st_addr_lo_i;
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    ld_data_o = shifted;
    case (ld_size_i)
      SIZE_B:  ld_data_o = {{24{ld_sgn_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  ld_data_o = {{16{ld_sgn_i & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_axil_master.sv
// AXI4-Lite master for the LSU: one request in, one AXI-Lite read or write
// out, one registered response back. Misaligned requests never reach the bus.
module ysyx_25020037_axil_master
  import ysyx_25020037_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  ctl_t                ctl_q, ctl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [31:0]         st_wdata, ld_data;
  logic [3:0]          st_wstrb;
  logic                aw_fire, w_fire;

  ysyx_25020037_lsu_lane u_lane (
    .st_size_i    (req_size_i),
    .st_addr_lo_i (req_addr_i[1:0]),
    .st_data_i    (req_wdata_i),
    .st_wdata_o   (st_wdata),
    .st_wstrb_o   (st_wstrb),
    .ld_size_i    (ctl_q.size),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_sgn_i     (ctl_q.sgn),
    .ld_rdata_i   (rdata_i),
    .ld_data_o    (ld_data)
  );

  assign aw_fire = awvalid_q & awready_i;
  assign w_fire  = wvalid_q & wready_i;

  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        ctl_d   = '{sgn: req_signed_i, size: req_size_i};
        addr_d  = req_addr_i;
        wdata_d = st_wdata;
        wstrb_d = st_wstrb;
        if (is_bad_req(req_size_i, req_addr_i[1:0])) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_RESP;
        end else if (req_wen_i) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_REQ;
        end else begin
          arvalid_d = 1'b1;
          state_d   = S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (arready_i) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_RD_DATA;
      end
      S_RD_DATA: if (rvalid_i && rready_q) begin
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = is_err_resp(rresp_i);
        rsp_rdata_d = is_err_resp(rresp_i) ? '0 : ld_data;
        state_d     = S_RESP;
      end
      S_WR_REQ: begin
        // AW and W complete independently; B is only accepted after both
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: if (bvalid_i && bready_q) begin
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = is_err_resp(bresp_i);
        rsp_rdata_d = '0;
        state_d     = S_RESP;
      end
      S_RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ctl_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign araddr_o    = addr_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign awaddr_o    = addr_q;
  assign awvalid_o   = awvalid_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;

endmodule

// File: tb/tb_ysyx_25020037_axil_master.sv
// Randomized bench for the AXI-Lite master: a cycle-stepped responder with
// programmable wait states and an arithmetic reference model of the response.
module tb_ysyx_25020037_axil_master;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, wdata, rdata = '0;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [3:0]  wstrb;

  int n_tests = 0, n_fail = 0;

  ysyx_25020037_axil_master dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_signed_i(req_signed),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] lo,
                                             input logic [1:0] sz, input logic sgn);
    logic [31:0] lane, v;
    lane = d >> (8 * lo);
    v = lane;
    if (sz == 2'd0) begin
      v = lane & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = lane & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One complete transaction; the bench plays the AXI responder, deciding its
  // inputs each negedge so handshakes land on the following posedge.
  task automatic run_txn(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] size, input logic sgn,
                         input logic [31:0] rd, input logic [1:0] resp,
                         input int arw, input int rw, input int aww, input int ww,
                         input int bw, input int hold);
    logic        bad, e_err, rpend, bpend, seen, done;
    logic [31:0] e_rdata, e_wdata, cap_ar, cap_aw, cap_wd;
    logic [3:0]  e_wstrb, cap_ws;
    int          e_lat, lat, k, hcnt, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    e_err   = bad || resp >= 2'd2;
    e_rdata = (e_err || wen) ? 32'h0 : model_load(rd, addr[1:0], size, sgn);
    e_wdata = (size == 2'd0) ? (wd & 32'hFF) * 32'h0101_0101 :
              (size == 2'd1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    e_wstrb = (size == 2'd0) ? 4'(1 << addr[1:0]) : (size == 2'd1) ? 4'(3 << addr[1:0]) : 4'hF;
    e_lat   = bad ? 0 : wen ? 2 + ((aww > ww) ? aww : ww) + bw : 2 + arw + rw;
    rpend = 0; bpend = 0; seen = 0; done = 0; lat = -1; k = 0; hcnt = hold;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    cap_ar = '0; cap_aw = '0; cap_wd = '0; cap_ws = '0;
    @(negedge clk);
    chk({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = size; req_signed = sgn;
    @(posedge clk);
    while (!done && k < 60) begin
      @(negedge clk);
      // Later request-side changes must be ignored
      req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
      req_size = 2'($urandom); req_signed = 1'($urandom); req_wen = 1'($urandom);
      rvalid = 0;
      if (rpend) begin
        if (rw > 0) rw--;
        else begin
          rvalid = 1; rdata = rd; rresp = resp;
          if (rready) begin r_hs++; rpend = 0; end
        end
      end
      bvalid = 0;
      if (bpend) begin
        if (bw > 0) bw--;
        else begin
          bvalid = 1; bresp = resp;
          if (bready) begin b_hs++; bpend = 0; end
        end
      end
      arready = 0;
      if (arvalid) begin
        if (arw > 0) arw--;
        else begin arready = 1; ar_hs++; cap_ar = araddr; rpend = 1; end
      end
      awready = 0;
      if (awvalid) begin
        if (aww > 0) aww--;
        else begin awready = 1; aw_hs++; cap_aw = awaddr; end
      end
      wready = 0;
      if (wvalid) begin
        if (ww > 0) ww--;
        else begin wready = 1; w_hs++; cap_wd = wdata; cap_ws = wstrb; end
      end
      if (aw_hs == 1 && w_hs == 1 && b_hs == 0 && !bpend && (awready || wready)) bpend = 1;
      rsp_ready = 0;
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1; lat = k;
          chk({tag, "/latency"}, 32'(lat), 32'(e_lat));
        end else chk({tag, "/req_ready_busy"}, 32'(req_ready), 32'd0);
        chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(e_err));
        chk({tag, "/rsp_rdata"}, rsp_rdata, e_rdata);
        if (hcnt > 0) hcnt--;
        else begin rsp_ready = 1; done = 1; end
      end
      k++;
    end
    if (!done) chk({tag, "/timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0; arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    chk({tag, "/rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/req_ready_back"}, 32'(req_ready), 32'd1);
    chk({tag, "/ar_hs"}, 32'(ar_hs), 32'((!bad && !wen) ? 1 : 0));
    chk({tag, "/r_hs"},  32'(r_hs),  32'((!bad && !wen) ? 1 : 0));
    chk({tag, "/aw_hs"}, 32'(aw_hs), 32'((!bad && wen) ? 1 : 0));
    chk({tag, "/w_hs"},  32'(w_hs),  32'((!bad && wen) ? 1 : 0));
    chk({tag, "/b_hs"},  32'(b_hs),  32'((!bad && wen) ? 1 : 0));
    if (!bad && !wen) chk({tag, "/araddr"}, cap_ar, addr);
    if (!bad && wen) begin
      chk({tag, "/awaddr"}, cap_aw, addr);
      chk({tag, "/wdata"}, cap_wd, e_wdata);
      chk({tag, "/wstrb"}, 32'(cap_ws), 32'(e_wstrb));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/valids", 32'({arvalid, rready, awvalid, wvalid, bready, rsp_valid}), 32'd0);
    chk("rst/rsp_err", 32'(rsp_err), 32'd0);
    chk("rst/rsp_rdata", rsp_rdata, 32'd0);
    chk("rst/araddr", araddr, 32'd0);
    chk("rst/wdata", wdata, 32'd0);
    chk("rst/wstrb", 32'(wstrb), 32'd0);
    rst_n = 1;

    //         tag        wen addr          wdata         sz   sg rdata         resp  ar r aw w b hold
    run_txn("lw_ok",     0, 32'h0200_0000, 32'h0,        2'd2, 0, 32'h1234_5678, 2'd0, 0, 0, 0, 0, 0, 0);
    run_txn("lb_s",      0, 32'h8000_0003, 32'h0,        2'd0, 1, 32'h80FF_FFFF, 2'd0, 0, 0, 0, 0, 0, 0);
    run_txn("lb_u",      0, 32'h8000_0003, 32'h0,        2'd0, 0, 32'h80FF_FFFF, 2'd0, 0, 0, 0, 0, 0, 0);
    run_txn("sh_wlate",  1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 0, 32'h0,        2'd0, 0, 0, 0, 3, 0, 0);
    run_txn("lw_mis",    0, 32'h8000_0001, 32'h0,        2'd2, 0, 32'h0,        2'd0, 0, 0, 0, 0, 0, 0);
    run_txn("sw_slverr", 1, 32'h8000_0010, 32'h5555_AAAA, 2'd2, 0, 32'h0,        2'd2, 0, 0, 1, 0, 2, 0);
    run_txn("lw_decerr", 0, 32'h8000_0020, 32'h0,        2'd2, 0, 32'hDEAD_BEEF, 2'd3, 1, 2, 0, 0, 0, 0);
    run_txn("lh_exok",   0, 32'h8000_0022, 32'h0,        2'd1, 1, 32'h9ABC_1234, 2'd1, 0, 0, 0, 0, 0, 0);
    run_txn("lw_hold5",  0, 32'h0200_0004, 32'h0,        2'd2, 0, 32'hCAFE_F00D, 2'd0, 0, 0, 0, 0, 0, 5);
    run_txn("sz_resv",   1, 32'h8000_0000, 32'h1,        2'd3, 0, 32'h0,        2'd0, 0, 0, 0, 0, 0, 0);

    // Reset while waiting for R: everything drops on the next edge
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0040; req_size = 2'd2; arready = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    arready = 0;
    chk("rstmid/in_rd_data", 32'(rready), 32'd1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid/valids", 32'({arvalid, rready, awvalid, wvalid, bready, rsp_valid}), 32'd0);
    chk("rstmid/req_ready", 32'(req_ready), 32'd1);
    rst_n = 1;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] sz, lo;
      sz = 2'($urandom_range(0, 3));
      lo = 2'($urandom);
      run_txn($sformatf("rnd%0d", i), 1'($urandom), {$urandom} & 32'hFFFF_FFFC | 32'(lo),
              $urandom, sz, 1'($urandom), $urandom, 2'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
